alu_flag_branch: RTL

Flag register and branch-resolution unit on the consumer side of the 16-bit ALU. It captures the Z/OV/N outputs of each valid ALU operation under per-opcode update rules. It evaluates 3-bit branch conditions against the committed flags and produces a registered taken/target redirect for the fetch stage one cycle later. It also keeps a saturating taken-branch counter for performance debug.

---
 rtl/alu_flag_branch_if.sv | 36 +++
 rtl/alu_flag_branch.sv | 56 +++++
 2 files changed

// File: rtl/alu_flag_branch_if.sv
// alu_flag_branch_if: ALU flag capture, branch request and resolution signals between EX and the flag/branch unit
interface alu_flag_branch_if;
    logic        i_alu_vld;
    logic [2:0]  i_alu_op;
    logic        i_z_in;
    logic        i_ov_in;
    logic        i_n_in;
    logic        i_br_vld;
    logic [2:0]  i_br_cond;
    logic [15:0] i_br_pc;
    logic [8:0]  i_br_off;
    logic        i_stall;
    logic        i_flush;
    logic        i_cnt_clr;
    logic        o_z;
    logic        o_ov;
    logic        o_n;
    logic        o_resolve_vld;
    logic        o_take;
    logic [15:0] o_tgt;
    logic [15:0] o_taken_cnt;

    modport slave (
        input  i_alu_vld, i_alu_op, i_z_in, i_ov_in, i_n_in,
        input  i_br_vld, i_br_cond, i_br_pc, i_br_off,
        input  i_stall, i_flush, i_cnt_clr,
        output o_z, o_ov, o_n, o_resolve_vld, o_take, o_tgt, o_taken_cnt
    );

    modport master (
        output i_alu_vld, i_alu_op, i_z_in, i_ov_in, i_n_in,
        output i_br_vld, i_br_cond, i_br_pc, i_br_off,
        output i_stall, i_flush, i_cnt_clr,
        input  o_z, o_ov, o_n, o_resolve_vld, o_take, o_tgt, o_taken_cnt
    );
endinterface

// File: rtl/alu_flag_branch.sv
// alu_flag_branch: committed ALU flags, registered branch resolution and saturating taken-branch counter
module alu_flag_branch (
    input logic              i_clk,
    input logic              i_rst_n,
    alu_flag_branch_if.slave bus
);
    logic        r_z, r_ov, r_n, r_resolve_vld, r_take;
    logic [15:0] r_tgt, r_taken_cnt;
    logic        w_ex, w_alu_go, w_br_go, w_ld_zn, w_ld_ov, w_cond, w_inc;
    logic [7:0]  w_cond_vec;
    logic [15:0] w_tgt;

    assign w_ex     = !bus.i_stall && !bus.i_flush;
    assign w_alu_go = bus.i_alu_vld && w_ex;
    assign w_br_go  = bus.i_br_vld && w_ex;
    assign w_ld_ov  = bus.i_alu_op[2:1] == 2'b00;
    assign w_ld_zn  = !(bus.i_alu_op[2] && bus.i_alu_op[1]);
    // Bit k is the outcome of condition code k, evaluated on the committed (old) flags
    assign w_cond_vec = {1'b1, r_ov, r_n | r_z, r_z | !r_n, r_n, !r_z && !r_n, r_z, !r_z};
    assign w_cond     = w_cond_vec[bus.i_br_cond];
    assign w_tgt      = bus.i_br_pc + {{7{bus.i_br_off[8]}}, bus.i_br_off};
    assign w_inc      = w_br_go && w_cond && (r_taken_cnt != 16'hFFFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_z           <= 1'b0;
            r_ov          <= 1'b0;
            r_n           <= 1'b0;
            r_resolve_vld <= 1'b0;
            r_take        <= 1'b0;
            r_tgt         <= 16'h0000;
            r_taken_cnt   <= 16'h0000;
        end else begin
            if (w_alu_go && w_ld_zn) begin
                r_z <= bus.i_z_in;
                r_n <= bus.i_n_in;
            end
            if (w_alu_go && w_ld_ov)
                r_ov <= bus.i_ov_in;
            r_resolve_vld <= w_br_go;
            if (w_br_go) begin
                r_take <= w_cond;
                r_tgt  <= w_tgt;
            end
            r_taken_cnt <= bus.i_cnt_clr ? 16'h0000 : w_inc ? r_taken_cnt + 16'd1 : r_taken_cnt;
        end
    end

    assign bus.o_z           = r_z;
    assign bus.o_ov          = r_ov;
    assign bus.o_n           = r_n;
    assign bus.o_resolve_vld = r_resolve_vld;
    assign bus.o_take        = r_take;
    assign bus.o_tgt         = r_tgt;
    assign bus.o_taken_cnt   = r_taken_cnt;
endmodule
